// File: rtl/spad_pkg.sv
// Shared widths and the reader state encoding for the PE scratch pad read path.
package spad_pkg;

  localparam int unsigned SPAD_DATA_WIDTH = 16;
  localparam int unsigned SPAD_NUM_REGS   = 9;
  localparam int unsigned SPAD_ADDR_WIDTH = $clog2(SPAD_NUM_REGS);
  localparam int unsigned SPAD_REP_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/spad_addr_gen.sv
// Window address generator: latches base/len/rep, walks idx over each pass,
// counts passes, and wraps base+idx modulo NUM_REGS.
module spad_addr_gen #(
  parameter int unsigned NUM_REGS   = 9,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int unsigned REP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [REP_WIDTH-1:0]  rep_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  idx_last_o,
  output logic                  fetch_last_o
);

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [REP_WIDTH-1:0]  pass_q, pass_d;

  logic [ADDR_WIDTH:0]   len_m1;
  logic [ADDR_WIDTH:0]   sum;
  logic [ADDR_WIDTH:0]   wrapped;

  // Position flags and the modulo-NUM_REGS address.
  always_comb begin
    len_m1       = len_q - (ADDR_WIDTH+1)'(1);
    idx_last_o   = ({1'b0, idx_q} == len_m1);
    fetch_last_o = idx_last_o && (pass_q == rep_q);
    sum          = {1'b0, base_q} + {1'b0, idx_q};
    wrapped      = sum;
    if (sum >= (ADDR_WIDTH+1)'(NUM_REGS)) begin
      wrapped = sum - (ADDR_WIDTH+1)'(NUM_REGS);
    end
    rd_addr_o = wrapped[ADDR_WIDTH-1:0];
  end

  // Command latch and idx/pass counter next-state.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    rep_d  = rep_q;
    idx_d  = idx_q;
    pass_d = pass_q;
    if (load_i) begin
      base_d = base_i;
      len_d  = len_i;
      rep_d  = rep_i;
      idx_d  = '0;
      pass_d = '0;
    end else if (advance_i) begin
      if (idx_last_o) begin
        idx_d  = '0;
        pass_d = pass_q + REP_WIDTH'(1);
      end else begin
        idx_d  = idx_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Counter and command registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      len_q  <= '0;
      rep_q  <= '0;
      idx_q  <= '0;
      pass_q <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      rep_q  <= rep_d;
      idx_q  <= idx_d;
      pass_q <= pass_d;
    end
  end

endmodule

// File: rtl/spad_stream_reader.sv
// Read-side sequencer for the PE scratch pad: streams a repeated address
// window to the MAC datapath over valid/ready with a registered output slot.
// Optional macro SPAD_RD_STALL_CNT_EN adds a saturating stall_cnt output.
module spad_stream_reader #(
  parameter int unsigned DATA_WIDTH = spad_pkg::SPAD_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = spad_pkg::SPAD_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int unsigned REP_WIDTH  = spad_pkg::SPAD_REP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [REP_WIDTH-1:0]  rep,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] spad_rd_addr,
  input  logic [DATA_WIDTH-1:0] spad_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef SPAD_RD_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  out_last
);

  import spad_pkg::*;

  rd_state_e             state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  done_q, done_d;

  logic slot_free;
  logic cmd_accept;
  logic advance;
  logic idx_last;
  logic fetch_last;

  assign slot_free  = !out_valid_q || out_ready;
  assign cmd_accept = (state_q == ST_IDLE) && start && (len != '0);
  assign advance    = (state_q == ST_RUN) && slot_free;

  spad_addr_gen #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REP_WIDTH  (REP_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .rstn         (rstn),
    .load_i       (cmd_accept),
    .base_i       (base_addr),
    .len_i        (len),
    .rep_i        (rep),
    .advance_i    (advance),
    .rd_addr_o    (spad_rd_addr),
    .idx_last_o   (idx_last),
    .fetch_last_o (fetch_last)
  );

  // Sequencer and output-slot next-state.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) state_d = ST_RUN;
          else           done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          out_data_d  = spad_rd_data;
          out_valid_d = 1'b1;
          out_last_d  = idx_last;
          if (fetch_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

`ifdef SPAD_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the consumer holds off a valid word.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_spad_stream_reader.sv
// Self-checking bench for spad_stream_reader: table of directed commands
// plus hand-written reset and edge sequences.
module tb_spad_stream_reader;

  localparam int NREG = 9;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  len;
  logic [3:0]  rep;
  logic        busy;
  logic        done;
  logic [3:0]  spad_rd_addr;
  logic [15:0] spad_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
`ifdef SPAD_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] regs [NREG];

  int checks;
  int failures;

  spad_stream_reader dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_addr    (base_addr),
    .len          (len),
    .rep          (rep),
    .busy         (busy),
    .done         (done),
    .spad_rd_addr (spad_rd_addr),
    .spad_rd_data (spad_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef SPAD_RD_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    spad_rd_data = 16'hDEAD;
    if (spad_rd_addr < 4'(NREG)) spad_rd_data = regs[spad_rd_addr];
  end

  typedef struct {
    int base;
    int len;
    int rep;
    int stall_beat;
    int stall_len;
    int extra_start;
    int exp_beats;
    int exp_lasts;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int c;
    int bi;
    int stalled;
    int lasts;
    int done_cnt;
    int done_cycle;
    int exp_word;
    @(negedge clk);
    base_addr = 4'(v.base);
    len       = 5'(v.len);
    rep       = 4'(v.rep);
    start     = 1'b1;
    out_ready = 1'b1;
    bi = 0; stalled = 0; lasts = 0; done_cnt = 0; done_cycle = -1;
    for (c = 1; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == v.extra_start) begin
        start = 1'b1; base_addr = 4'd5; len = 5'd1; rep = 4'd0;
      end else begin
        base_addr = 4'(v.base); len = 5'(v.len); rep = 4'(v.rep);
      end
      if (c == 1) chk("busy_after_start", {31'd0, busy}, {31'd0, v.len != 0});
      if (done) begin
        done_cnt++;
        done_cycle = c;
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("valid_at_done", {31'd0, out_valid}, 32'd0);
      end
      if (v.stall_len == 0 && c <= v.exp_beats)
        chk("rd_addr", {28'd0, spad_rd_addr}, (v.base + (c - 1) % v.len) % NREG);
      out_ready = 1'b1;
      if (out_valid) begin
        if (v.len == 0 || bi >= v.exp_beats) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_word = 'hA0 + (v.base + bi % v.len) % NREG;
          chk("out_data", {16'd0, out_data}, exp_word);
          chk("out_last", {31'd0, out_last}, {31'd0, (bi % v.len) == v.len - 1});
          if (bi == 0) chk("first_beat_cycle", c, 2);
          if (bi == v.stall_beat && stalled < v.stall_len) begin
            out_ready = 1'b0;
            stalled++;
          end else begin
            if (out_last) lasts++;
            bi++;
          end
        end
      end
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
    end
    chk("beats", bi, v.exp_beats);
    chk("lasts", lasts, v.exp_lasts);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cycle, v.exp_done);
`ifdef SPAD_RD_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, v.stall_len);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_last"},  {31'd0, out_last}, 32'd0);
    chk({tag, "_data"},  {16'd0, out_data}, 32'd0);
    chk({tag, "_addr"},  {28'd0, spad_rd_addr}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    checks = 0;
    failures = 0;
    for (int i = 0; i < NREG; i++) regs[i] = 16'h00A0 + 16'(i);

    //          base len rep sb  sl  xs  beats lasts done
    vecs[0] = '{2,   3,  0,  -1, 0,  3,  3,    1,    5};
    vecs[1] = '{7,   4,  0,  -1, 0,  -1, 4,    1,    6};
    vecs[2] = '{0,   2,  2,  -1, 0,  -1, 6,    3,    8};
    vecs[3] = '{4,   3,  0,  1,  3,  -1, 3,    1,    8};
    vecs[4] = '{0,   0,  0,  -1, 0,  -1, 0,    0,    1};
    vecs[5] = '{0,   9,  1,  -1, 0,  -1, 18,   2,    20};
    vecs[6] = '{8,   9,  0,  -1, 0,  -1, 9,    1,    11};

    rstn = 1'b0; start = 1'b0; base_addr = '0; len = '0; rep = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Reset during the second beat of a full-length window.
    @(negedge clk);
    base_addr = 4'd0; len = 5'd9; rep = 4'd0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_seq_beat0", {16'd0, out_data}, 32'hA0);
    @(negedge clk);
    chk("rst_seq_beat1", {16'd0, out_data}, 32'hA1);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    rv = '{3, 2, 0, -1, 0, -1, 2, 1, 4};
    run_cmd(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spad_stream_reader.md
Name: spad_stream_reader

Overview:
- Read-side sequencer for the PE register scratch pad (9 x 16-bit, single cycle, combinational read).
- Owns the pad's read_addr port and walks a programmed window base..base+len-1, wrapping modulo NUM_REGS.
- Repeats the window (rep+1) times to model filter-row reuse, then streams words to the MAC datapath over a valid/ready interface with full backpressure and 1 word/cycle throughput.

Parameters:
- DATA_WIDTH, 16, word width; must match the scratch pad.
- NUM_REGS, 9, scratch pad depth.
- ADDR_WIDTH, $clog2(NUM_REGS), address width.
- REP_WIDTH, 4, width of the repeat-count field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of the window; must be < NUM_REGS.
- len  in  ADDR_WIDTH+1  words per pass; legal range 0..NUM_REGS.
- rep  in  REP_WIDTH  extra passes; total passes = rep+1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- spad_rd_addr  out  ADDR_WIDTH  to scratch pad read_addr.
- spad_rd_data  in  DATA_WIDTH  from scratch pad read_data; combinational from spad_rd_addr.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  registered data word.
- out_last  out  1  qualifies the last word of each pass.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, spad_rd_addr=0. FSM returns to IDLE and all counters clear. Reset mid-stream aborts immediately with no done pulse.
- FSM states:
  - IDLE: start=1 with len!=0 latches base, len and rep, and moves to RUN. start=1 with len=0 pulses done the next cycle and stays in IDLE with no beats.
  - RUN: issue fetches.
  - DRAIN: the last fetch has been issued; wait for the final beat to be accepted.
- Output register:
  - "slot free" means out_valid=0 or out_ready=1.
  - In RUN, when the slot is free, out_data<=spad_rd_data, out_valid<=1, and out_last<=(idx==len-1); then idx advances.
  - When the slot is not free, hold spad_rd_addr, out_data and out_last stable.
- Latency: start accepted at cycle T; first out_valid at T+2 (T+1 latches the command and drives the first address). Steady-state rate is 1 beat/cycle while out_ready=1.
- Address: spad_rd_addr = base+idx; if that is >= NUM_REGS, subtract NUM_REGS. Valid for any len<=NUM_REGS.
- Pass handling: when idx reaches len-1 and the fetch is issued, idx<=0 and pass<=pass+1. After the fetch with pass==rep and idx==len-1, go to DRAIN.
- DRAIN: the accepted beat (out_valid & out_ready) sets out_valid<=0; done pulses in the same cycle the register updates; return to IDLE and drop busy.
- Backpressure: out_valid never drops without acceptance, and out_data never changes while out_valid=1 and out_ready=0.
- start while busy is ignored.
- Scratch pad contents must not change during a command; the block does not check this.

Optional Feature:
- Macro: SPAD_RD_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits).
  - Counts cycles with out_valid=1 and out_ready=0; saturates at 0xFFFF.
  - Clears on an accepted start; holds after done; reset value 0.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

Decomposition:
- Package spad_pkg: SPAD_DATA_WIDTH=16, SPAD_NUM_REGS=9, SPAD_ADDR_WIDTH, and the reader state enum (IDLE, RUN, DRAIN).
- One sub-module, spad_addr_gen: idx/pass counters, modulo-NUM_REGS wrap adder, and the last-fetch flag, with an advance input driven by "slot free".

Test Plan:
Scratch pad preloaded with regs[i]=16'h00A0+i.
- Plain pass: base=2, len=3, rep=0, out_ready=1 -> beats A2,A3,A4 on cycles T+2..T+4; out_last on A4; done at T+5 with busy low.
- Wrap: base=7, len=4, rep=0 -> A7,A8,A0,A1; spad_rd_addr sequence 7,8,0,1.
- Repeat: base=0, len=2, rep=2 -> A0,A1,A0,A1,A0,A1; out_last on every A1; exactly one done pulse.
- Backpressure: base=4, len=3, out_ready low for 3 cycles at the second beat -> A5 held stable with out_valid=1; sequence A4,A5,A6 intact; stall_cnt=3 when the macro is defined.
- Edge commands: len=0 -> done next cycle, no out_valid. start asserted while busy -> ignored, stream unchanged.
- Reset mid-stream: rstn low during the 2nd beat of len=9 -> all outputs 0 immediately, no done; a new start after release streams correctly.
